// File: rtl/chiptester_pkg.sv
// Shared chip-tester definitions: checker FSM states and default widths.
package chiptester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_RTF_WIDTH = 24;
  localparam int DEF_CNT_WIDTH = 16;
  localparam int DEF_TIMEOUT   = 4096;

endpackage

// File: rtl/result_cmp.sv
// Result vs expected comparator; per-bit mask when RESULT_CHECKER_MASK_EN
// is defined, exact full-width compare otherwise.
module result_cmp
  import chiptester_pkg::*;
#(
  parameter int W = DEF_RTF_WIDTH
) (
  input  logic [W-1:0] i_got,
  input  logic [W-1:0] i_exp,
`ifdef RESULT_CHECKER_MASK_EN
  input  logic [W-1:0] i_mask,
`endif
  output logic         o_mismatch
);

`ifdef RESULT_CHECKER_MASK_EN
  assign o_mismatch = |((i_got ^ i_exp) & i_mask);
`else
  assign o_mismatch = |(i_got ^ i_exp);
`endif

endmodule

// File: rtl/result_checker.sv
// RES_FIFO reader / checker against EXP_FIFO with error capture and timeout.
// Build option: RESULT_CHECKER_MASK_EN (efifo_q = {mask, expected}).
module result_checker
  import chiptester_pkg::*;
#(
  parameter int RTF_WIDTH = DEF_RTF_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [RTF_WIDTH-1:0] rfifo_q,
  output logic                 rfifo_rdreq,
  input  logic                 rfifo_rdempty,
`ifdef RESULT_CHECKER_MASK_EN
  input  logic [2*RTF_WIDTH-1:0] efifo_q,
`else
  input  logic [RTF_WIDTH-1:0] efifo_q,
`endif
  output logic                 efifo_rdreq,
  input  logic                 efifo_rdempty,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] vec_count,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] first_err_idx,
  output logic [RTF_WIDTH-1:0] first_err_got,
  output logic [RTF_WIDTH-1:0] first_err_exp
);

  localparam int ST_W = $clog2(TIMEOUT + 1);
  localparam logic [ST_W-1:0] STALL_LAST = ST_W'(TIMEOUT - 1);
  localparam logic [ST_W-1:0] ST_ONE = ST_W'(1);
  localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

  state_t r_state;
  state_t w_next;

  logic [CNT_WIDTH-1:0] r_target;
  logic [CNT_WIDTH-1:0] r_issued;
  logic [CNT_WIDTH-1:0] r_checked;
  logic [CNT_WIDTH-1:0] r_err;
  logic [CNT_WIDTH-1:0] r_fidx;
  logic [RTF_WIDTH-1:0] r_fgot;
  logic [RTF_WIDTH-1:0] r_fexp;
  logic [ST_W-1:0]      r_stall;
  logic                 r_cmp_valid;
  logic                 r_timeout;

  logic [RTF_WIDTH-1:0] w_exp;
  logic w_pop;
  logic w_arm;
  logic w_mismatch;
  logic w_last_cmp;
  logic w_stall_hit;

  assign w_exp = efifo_q[RTF_WIDTH-1:0];

  result_cmp #(
    .W(RTF_WIDTH)
  ) u_cmp (
    .i_got     (rfifo_q),
    .i_exp     (w_exp),
`ifdef RESULT_CHECKER_MASK_EN
    .i_mask    (efifo_q[2*RTF_WIDTH-1:RTF_WIDTH]),
`endif
    .o_mismatch(w_mismatch)
  );

  assign w_pop = (r_state == ST_RUN)
               & ~rfifo_rdempty
               & ~efifo_rdempty
               & (r_issued < r_target)
               & ~abort;

  assign w_arm = start & ~abort
               & (r_state != ST_RUN);

  assign w_last_cmp = r_cmp_valid
                    & ((r_checked + C_ONE) == r_target);

  assign w_stall_hit = ~w_pop
                     & (r_stall == STALL_LAST);

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start)
            w_next = (vec_count == '0) ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          if (w_last_cmp | w_stall_hit)
            w_next = ST_DONE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rfifo_rdreq = w_pop;
    efifo_rdreq = w_pop;
    busy        = (r_state == ST_RUN);
    done        = (r_state == ST_DONE);
    pass        = done & (r_err == '0) & ~r_timeout;
    timeout     = r_timeout;
  end

  // Compare happens the cycle after a pop, when the FIFO data is valid.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_target    <= '0;
      r_issued    <= '0;
      r_checked   <= '0;
      r_err       <= '0;
      r_fidx      <= '0;
      r_fgot      <= '0;
      r_fexp      <= '0;
      r_stall     <= '0;
      r_cmp_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_cmp_valid <= w_pop;
      if (abort) begin
        r_stall   <= '0;
        r_timeout <= 1'b0;
      end else if (w_arm) begin
        r_target  <= vec_count;
        r_issued  <= '0;
        r_checked <= '0;
        r_err     <= '0;
        r_fidx    <= '0;
        r_fgot    <= '0;
        r_fexp    <= '0;
        r_stall   <= '0;
        r_timeout <= 1'b0;
      end else if (r_state == ST_RUN) begin
        if (w_pop) begin
          r_issued <= r_issued + C_ONE;
          r_stall  <= '0;
        end else begin
          r_stall  <= r_stall + ST_ONE;
        end
        if (r_cmp_valid) begin
          r_checked <= r_checked + C_ONE;
          if (w_mismatch) begin
            if (r_err != '1)
              r_err <= r_err + C_ONE;
            if (r_err == '0) begin
              r_fidx <= r_checked;
              r_fgot <= rfifo_q;
              r_fexp <= w_exp;
            end
          end
        end
        if (w_stall_hit & ~w_last_cmp)
          r_timeout <= 1'b1;
      end
    end
  end

  assign err_count     = r_err;
  assign first_err_idx = r_fidx;
  assign first_err_got = r_fgot;
  assign first_err_exp = r_fexp;

endmodule
